// File: rtl/window_row_buffer.sv
// Sliding F-row window over a stream of feature-map rows, zero-padded on all sides,
// with valid/ready on both the row input and the window output.
module window_row_buffer #(
    parameter int W         = 24,
    parameter int H         = 24,
    parameter int C         = 1,
    parameter int DATA_BITS = 8,
    parameter int F         = 3
) (
    input  logic                                          clk,
    input  logic                                          reset,
    input  logic                                          flush,
    input  logic [C*W*DATA_BITS-1:0]                      in_data,
    input  logic                                          in_valid,
    output logic                                          in_ready,
    output logic [F*C*(W+2*((F-1)/2))*DATA_BITS-1:0]      out_rows,
    output logic                                          out_valid,
    input  logic                                          out_ready,
    output logic [((H > 1) ? $clog2(H) : 1)-1:0]          out_row_idx,
    output logic                                          frame_done
);

    localparam int PAD       = (F - 1) / 2;
    localparam int PIX_BITS  = C * DATA_BITS;
    localparam int ROW_BITS  = W * PIX_BITS;
    localparam int PROW_BITS = (W + 2 * PAD) * PIX_BITS;
    localparam int CNT_BITS  = $clog2(H + 1);
    localparam int IDX_BITS  = (H > 1) ? $clog2(H) : 1;
    localparam int SLOT_BITS = $clog2(F);

    logic [CNT_BITS-1:0]  rows_in;
    logic [CNT_BITS-1:0]  rows_out;
    logic [SLOT_BITS-1:0] wr_slot;
    logic [ROW_BITS-1:0]  ring [F];
    logic                 in_fire;
    logic                 out_fire;
    logic                 last_out;
    int                   need_rows;

    // A new row may only overwrite the slot of row rows_in-F once every window using it is gone.
    always_comb begin
        in_ready = 1'b0;
        if (!reset && !flush && int'(rows_in) < H) begin
            in_ready = (int'(rows_in) < F) || (int'(rows_out) >= int'(rows_in) - PAD);
        end
    end

    always_comb begin
        need_rows = int'(rows_out) + PAD + 1;
        if (need_rows > H) begin
            need_rows = H;
        end
        out_valid = (int'(rows_out) < H) && (int'(rows_in) >= need_rows);
    end

    assign in_fire     = in_valid && in_ready;
    assign out_fire    = out_valid && out_ready;
    assign last_out    = (int'(rows_out) == H - 1);
    assign out_row_idx = IDX_BITS'(rows_out);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rows_in    <= '0;
            rows_out   <= '0;
            wr_slot    <= '0;
            frame_done <= 1'b0;
            for (int k = 0; k < F; k++) begin
                ring[k] <= '0;
            end
        end else begin
            frame_done <= 1'b0;
            if (flush) begin
                rows_in  <= '0;
                rows_out <= '0;
                wr_slot  <= '0;
            end else if (out_fire && last_out) begin
                rows_in    <= '0;
                rows_out   <= '0;
                wr_slot    <= '0;
                frame_done <= 1'b1;
            end else begin
                if (in_fire) begin
                    rows_in <= rows_in + CNT_BITS'(1);
                    wr_slot <= (wr_slot == SLOT_BITS'(F - 1)) ? '0 : wr_slot + SLOT_BITS'(1);
                end
                if (out_fire) begin
                    rows_out <= rows_out + CNT_BITS'(1);
                end
            end
            // in_ready is already low during flush and at frame end, so this write never collides.
            if (in_fire) begin
                ring[wr_slot] <= in_data;
            end
        end
    end

    for (genvar k = 0; k < F; k++) begin : g_slot
        int                   src;
        logic [SLOT_BITS-1:0] sel;
        logic                 in_frame;

        assign src      = int'(rows_out) - PAD + k;
        assign sel      = SLOT_BITS'(src % F);
        assign in_frame = (src >= 0) && (src < H);
        assign out_rows[k*PROW_BITS +: PROW_BITS] =
            in_frame ? {{(PAD*PIX_BITS){1'b0}}, ring[sel], {(PAD*PIX_BITS){1'b0}}} : '0;
    end

endmodule

// File: tb/tb_window_row_buffer.sv
// Scoreboard bench for window_row_buffer: an F=3 instance and an F=5/C=2 instance
// share the stimulus; one is active at a time and the model tracks its counters.
module tb_window_row_buffer;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         flush = 1'b0;
    logic [63:0]  in_data = '0;
    logic         in_valid_a = 1'b0, in_valid_b = 1'b0;
    logic         out_ready_a = 1'b0, out_ready_b = 1'b0;
    logic         in_ready_a, in_ready_b, out_valid_a, out_valid_b, done_a, done_b;
    logic [143:0] rows_a;
    logic [639:0] rows_b;
    logic [1:0]   idx_a;
    logic [2:0]   idx_b;

    always #5 clk = ~clk;

    window_row_buffer #(.W(4), .H(4), .C(1), .DATA_BITS(8), .F(3)) dut_a (
        .clk(clk), .reset(reset), .flush(flush), .in_data(in_data[31:0]),
        .in_valid(in_valid_a), .in_ready(in_ready_a), .out_rows(rows_a),
        .out_valid(out_valid_a), .out_ready(out_ready_a), .out_row_idx(idx_a),
        .frame_done(done_a));

    window_row_buffer #(.W(4), .H(6), .C(2), .DATA_BITS(8), .F(5)) dut_b (
        .clk(clk), .reset(reset), .flush(flush), .in_data(in_data),
        .in_valid(in_valid_b), .in_ready(in_ready_b), .out_rows(rows_b),
        .out_valid(out_valid_b), .out_ready(out_ready_b), .out_row_idx(idx_b),
        .frame_done(done_b));

    int cfg = 0, f = 3, h = 4, c = 1, pad = 1;
    int ri = 0, ro = 0, fr = 0, frames_done = 0, done_seen = 0;
    bit exp_done = 1'b0;
    int tests = 0, fails = 0;
    logic [639:0] exp_q [$];
    int           idx_q [$];

    logic [639:0] cur_rows;
    logic         cur_in_ready, cur_out_valid, cur_done;
    int           cur_idx;

    always_comb begin
        if (cfg == 0) begin
            cur_rows      = 640'(rows_a);
            cur_in_ready  = in_ready_a;
            cur_out_valid = out_valid_a;
            cur_done      = done_a;
            cur_idx       = int'(idx_a);
        end else begin
            cur_rows      = rows_b;
            cur_in_ready  = in_ready_b;
            cur_out_valid = out_valid_b;
            cur_done      = done_b;
            cur_idx       = int'(idx_b);
        end
    end

    task automatic checkOutput(input string tag, input logic [639:0] got, input logic [639:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] pix(int frame, int row, int px, int ch);
        return 8'(16 * row + px + 1 + 8 * ch + 64 * frame);
    endfunction

    function automatic logic [63:0] row_data(int frame, int row);
        logic [63:0] d = '0;
        for (int j = 0; j < 4; j++)
            for (int ch = 0; ch < c; ch++)
                d[(j * c + ch) * 8 +: 8] = pix(frame, row, j, ch);
        return d;
    endfunction

    function automatic logic [639:0] exp_window(int frame, int r);
        logic [639:0] w = '0;
        int prow = c * (4 + 2 * pad) * 8;
        for (int k = 0; k < f; k++) begin
            int src = r - pad + k;
            if (src >= 0 && src < h)
                for (int j = 0; j < 4; j++)
                    for (int ch = 0; ch < c; ch++)
                        w[k * prow + ((j + pad) * c + ch) * 8 +: 8] = pix(frame, src, j, ch);
        end
        return w;
    endfunction

    task automatic set_cfg(input int n);
        cfg = n;
        if (n == 0) begin f = 3; h = 4; c = 1; end
        else begin f = 5; h = 6; c = 2; end
        pad = (f - 1) / 2;
    endtask

    task automatic clear_model();
        ri = 0;
        ro = 0;
        exp_q.delete();
        idx_q.delete();
        exp_done = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        flush = 1'b0;
        in_valid_a = 1'b0; in_valid_b = 1'b0;
        out_ready_a = 1'b0; out_ready_b = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        clear_model();
    endtask

    // One clock of stimulus; all checks happen half a cycle before the edge that acts on it.
    task automatic applyStimulus(input bit vi, input bit vo, input bit fl);
        bit           exp_ready, in_fire, out_fire;
        int           qsize, id, lim;
        logic [639:0] w;
        @(negedge clk);
        flush       = fl;
        in_valid_a  = (cfg == 0) && vi;
        in_valid_b  = (cfg == 1) && vi;
        out_ready_a = (cfg == 0) && vo;
        out_ready_b = (cfg == 1) && vo;
        in_data     = row_data(fr, ri);
        #1;
        exp_ready = !fl && ri < h && (ri < f || ro >= ri - pad);
        qsize = exp_q.size();
        checkOutput("frame_done", cur_done, exp_done);
        if (cur_done) done_seen++;
        exp_done = 1'b0;
        checkOutput("in_ready", cur_in_ready, exp_ready);
        checkOutput("out_valid", cur_out_valid, qsize > 0);
        in_fire  = cur_in_ready && vi && !fl;
        out_fire = cur_out_valid && vo && !fl;
        if (fl) clear_model();
        if (in_fire) begin
            for (int r = 0; r < h; r++) begin
                lim = (r + pad < h - 1) ? r + pad : h - 1;
                if (lim == ri) begin
                    exp_q.push_back(exp_window(fr, r));
                    idx_q.push_back(r);
                end
            end
            ri++;
        end
        if (out_fire) begin
            if (qsize == 0) begin
                checkOutput("spurious window", 1, 0);
            end else begin
                w  = exp_q.pop_front();
                id = idx_q.pop_front();
                checkOutput("window", cur_rows, w);
                checkOutput("row_idx", cur_idx, id);
                ro++;
                if (ro == h) begin
                    ri = 0;
                    ro = 0;
                    fr++;
                    frames_done++;
                    exp_done = 1'b1;
                end
            end
        end
    endtask

    task automatic run_frames(input int n, input int pin, input int pout);
        int target = frames_done + n;
        int d0 = done_seen;
        int cyc = 0;
        while (frames_done < target && cyc < 3000) begin
            applyStimulus($urandom_range(0, 99) < pin, $urandom_range(0, 99) < pout, 1'b0);
            cyc++;
        end
        checkOutput("frames completed", frames_done, target);
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("queue drained", exp_q.size(), 0);
        checkOutput("frame_done count", done_seen - d0, n);
    endtask

    initial begin
        set_cfg(0);
        in_valid_a = 1'b1;
        #3;
        checkOutput("reset in_ready", cur_in_ready, 0);
        checkOutput("reset out_valid", cur_out_valid, 0);
        checkOutput("reset frame_done", cur_done, 0);
        checkOutput("reset row_idx", cur_idx, 0);
        checkOutput("reset out_rows", cur_rows, 0);

        do_reset();
        run_frames(1, 100, 100);

        do_reset();
        repeat (3) applyStimulus(1'b1, 1'b0, 1'b0);
        repeat (20) begin
            applyStimulus(1'b1, 1'b0, 1'b0);
            checkOutput("stall window", cur_rows, exp_window(fr, 0));
        end
        checkOutput("rows accepted", ri, 3);
        applyStimulus(1'b1, 1'b1, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0);
        checkOutput("row3 accepted", ri, 4);
        run_frames(1, 100, 100);

        set_cfg(1);
        do_reset();
        run_frames(1, 100, 100);
        run_frames(3, 50, 50);

        set_cfg(0);
        do_reset();
        run_frames(3, 50, 50);

        do_reset();
        applyStimulus(1'b1, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b0);
        @(negedge clk);
        in_valid_a = 1'b1;
        #2 reset = 1'b1;
        #1;
        checkOutput("midreset in_ready", cur_in_ready, 0);
        checkOutput("midreset out_valid", cur_out_valid, 0);
        checkOutput("midreset frame_done", cur_done, 0);
        checkOutput("midreset row_idx", cur_idx, 0);
        checkOutput("midreset out_rows", cur_rows, 0);
        clear_model();
        in_valid_a = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        run_frames(1, 100, 100);

        do_reset();
        applyStimulus(1'b1, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("flush row_idx", cur_idx, 0);
        run_frames(1, 100, 100);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
